// File: rtl/mac_pe_os.sv
// mac_pe_os: output-stationary MAC processing element for the systolic array.
// Activations and weights hop east/south one cycle per PE. Each PE accumulates
// a_in*w_in between first/last framing flags, with optional saturation. It then
// injects each finished result onto a per-column drain chain. Upstream drain
// traffic always has priority over the local result.
module mac_pe_os #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ACC_W       = 24,
  parameter int unsigned SIGNED_MODE = 1,
  parameter int unsigned SATURATE    = 1,
  parameter int unsigned PIPE_MULT   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] w_in,
  input  logic              valid_in,
  input  logic              first_in,
  input  logic              last_in,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] w_out,
  output logic              valid_out,
  output logic              first_out,
  output logic              last_out,
  input  logic [ACC_W-1:0]  res_in,
  input  logic              res_valid_in,
  output logic [ACC_W-1:0]  res_out,
  output logic              res_valid_out,
  input  logic              clr_flags,
  output logic              sat_flag,
  output logic              ovf_err
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  logic [DATA_W-1:0] a_q, w_q;
  logic              valid_q, first_q, last_q;

  // Unconditional one-hop forwarding of operands and framing flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      w_q     <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      a_q     <= a_in;
      w_q     <= w_in;
      valid_q <= valid_in;
      first_q <= first_in;
      last_q  <= last_in;
    end
  end

  logic signed [PROD_W-1:0] a_sx_c, w_sx_c, prod_s_c;
  logic        [PROD_W-1:0] prod_u_c;
  logic        [ACC_W-1:0]  prod_ext_c;

  // Full-width product, sign- or zero-extended to the accumulator width
  always_comb begin
    a_sx_c   = {{DATA_W{a_in[DATA_W-1]}}, a_in};
    w_sx_c   = {{DATA_W{w_in[DATA_W-1]}}, w_in};
    prod_s_c = a_sx_c * w_sx_c;
    prod_u_c = {{DATA_W{1'b0}}, a_in} * {{DATA_W{1'b0}}, w_in};
    if (SIGNED_MODE != 0) prod_ext_c = ACC_W'(prod_s_c);
    else                  prod_ext_c = ACC_W'(prod_u_c);
  end

  logic [ACC_W-1:0] st_prod;
  logic             st_valid, st_first, st_last;

  if (PIPE_MULT != 0) begin : g_pipe
    logic [ACC_W-1:0] s1_prod_q;
    logic             s1_valid_q, s1_first_q, s1_last_q;

    // Product stage register, carrying the beat flags alongside the product
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_prod_q  <= '0;
        s1_valid_q <= 1'b0;
        s1_first_q <= 1'b0;
        s1_last_q  <= 1'b0;
      end else begin
        s1_prod_q  <= prod_ext_c;
        s1_valid_q <= valid_in;
        s1_first_q <= first_in;
        s1_last_q  <= last_in;
      end
    end

    assign st_prod  = s1_prod_q;
    assign st_valid = s1_valid_q;
    assign st_first = s1_first_q;
    assign st_last  = s1_last_q;
  end else begin : g_comb
    assign st_prod  = prod_ext_c;
    assign st_valid = valid_in;
    assign st_first = first_in;
    assign st_last  = last_in;
  end

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] hold_q, hold_d;
  logic             hold_valid_q, hold_valid_d;
  logic [ACC_W-1:0] res_q, res_d;
  logic             res_valid_q, res_valid_d;
  logic             sat_q, sat_d;
  logic             ovf_q, ovf_d;

  logic [ACC_W:0]   sum_c;
  logic             range_ovf_c;
  logic             sat_hit_c;
  logic [ACC_W-1:0] acc_next_c;

  // Accumulate one guard bit wide; clamp to the representable range on overflow
  always_comb begin
    if (SIGNED_MODE != 0) begin
      sum_c       = {acc_q[ACC_W-1], acc_q} + {st_prod[ACC_W-1], st_prod};
      range_ovf_c = sum_c[ACC_W] ^ sum_c[ACC_W-1];
    end else begin
      sum_c       = {1'b0, acc_q} + {1'b0, st_prod};
      range_ovf_c = sum_c[ACC_W];
    end
    acc_next_c = sum_c[ACC_W-1:0];
    sat_hit_c  = 1'b0;
    if (st_first) begin
      acc_next_c = st_prod;
    end else if ((SATURATE != 0) && range_ovf_c) begin
      sat_hit_c = 1'b1;
      if (SIGNED_MODE != 0) begin
        acc_next_c = sum_c[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                  : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
        acc_next_c = '1;
      end
    end
  end

  logic capture_c, emit_c, drop_c;

  // Hold-register capture, drain arbitration and sticky flag update
  always_comb begin
    capture_c    = st_valid & st_last;
    emit_c       = ~res_valid_in & hold_valid_q;
    drop_c       = 1'b0;
    acc_d        = acc_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q & ~emit_c;
    res_d        = res_q;
    res_valid_d  = 1'b0;
    sat_d        = sat_q;
    ovf_d        = ovf_q;

    if (st_valid) acc_d = acc_next_c;

    if (capture_c) begin
      if (hold_valid_q && !emit_c) begin
        drop_c = 1'b1;
      end else begin
        hold_d       = acc_next_c;
        hold_valid_d = 1'b1;
      end
    end

    if (res_valid_in) begin
      res_d       = res_in;
      res_valid_d = 1'b1;
    end else if (hold_valid_q) begin
      res_d       = hold_q;
      res_valid_d = 1'b1;
    end

    if (clr_flags) begin
      sat_d = 1'b0;
      ovf_d = 1'b0;
    end
    if (st_valid && sat_hit_c) sat_d = 1'b1;
    if (drop_c)                ovf_d = 1'b1;
  end

  // Accumulator, hold, drain output and flag state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q        <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      res_q        <= '0;
      res_valid_q  <= 1'b0;
      sat_q        <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      res_q        <= res_d;
      res_valid_q  <= res_valid_d;
      sat_q        <= sat_d;
      ovf_q        <= ovf_d;
    end
  end

  assign a_out         = a_q;
  assign w_out         = w_q;
  assign valid_out     = valid_q;
  assign first_out     = first_q;
  assign last_out      = last_q;
  assign res_out       = res_q;
  assign res_valid_out = res_valid_q;
  assign sat_flag      = sat_q;
  assign ovf_err       = ovf_q;

endmodule

// File: tb/tb_mac_pe_os.sv
// tb_mac_pe_os: bench for mac_pe_os. Three instances share one stimulus stream:
// inst0 has the defaults, inst1 has PIPE_MULT=0 and inst2 has SATURATE=0.
// A per-cycle behavioural model is checked against every instance. Directed
// literal expectations check the model itself.
module tb_mac_pe_os;

  localparam int NI = 3;
  localparam longint ACC_MAX = 64'sd8388607;
  localparam longint ACC_MIN = -64'sd8388608;
  localparam longint MASK    = 64'sd16777215;
  localparam longint WRAP    = 64'sd16777216;

  logic        clk;
  logic        rst_n;
  logic [7:0]  a_in, w_in;
  logic        valid_in, first_in, last_in;
  logic [23:0] res_in;
  logic        res_valid_in;
  logic        clr_flags;

  logic [7:0]  a_out_w       [NI];
  logic [7:0]  w_out_w       [NI];
  logic        valid_out_w   [NI];
  logic        first_out_w   [NI];
  logic        last_out_w    [NI];
  logic [23:0] res_out_w     [NI];
  logic        res_valid_out_w [NI];
  logic        sat_flag_w    [NI];
  logic        ovf_err_w     [NI];

  int n_checks = 0;
  int n_errors = 0;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mac_pe_os #(
      .DATA_W(8), .ACC_W(24), .SIGNED_MODE(1),
      .SATURATE((g == 2) ? 0 : 1),
      .PIPE_MULT((g == 1) ? 0 : 1)
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .a_in         (a_in),
      .w_in         (w_in),
      .valid_in     (valid_in),
      .first_in     (first_in),
      .last_in      (last_in),
      .a_out        (a_out_w[g]),
      .w_out        (w_out_w[g]),
      .valid_out    (valid_out_w[g]),
      .first_out    (first_out_w[g]),
      .last_out     (last_out_w[g]),
      .res_in       (res_in),
      .res_valid_in (res_valid_in),
      .res_out      (res_out_w[g]),
      .res_valid_out(res_valid_out_w[g]),
      .clr_flags    (clr_flags),
      .sat_flag     (sat_flag_w[g]),
      .ovf_err      (ovf_err_w[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int inst, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s inst%0d got %0d expected %0d @%0t", name, inst, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    bit     v;
    bit     f;
    bit     l;
    longint p;
  } beat_t;

  beat_t      pq [NI][$];
  longint     m_acc [NI];
  longint     m_hold [NI];
  longint     m_res [NI];
  bit         m_hv [NI];
  bit         m_rv [NI];
  bit         m_sat [NI];
  bit         m_ovf [NI];
  logic [7:0] e_a, e_w;
  bit         e_v, e_f, e_l;

  function automatic int lat_of(input int i);
    return (i == 1) ? 0 : 1;
  endfunction

  function automatic bit sat_of(input int i);
    return (i != 2);
  endfunction

  task automatic model_reset();
    e_a = '0; e_w = '0; e_v = 0; e_f = 0; e_l = 0;
    for (int i = 0; i < NI; i++) begin
      pq[i].delete();
      m_acc[i] = 0; m_hold[i] = 0; m_res[i] = 0;
      m_hv[i] = 0; m_rv[i] = 0; m_sat[i] = 0; m_ovf[i] = 0;
    end
  endtask

  task automatic model_step(input logic [7:0] a, input logic [7:0] w,
                            input logic v, input logic f, input logic l,
                            input logic rv, input logic [23:0] rin, input logic clr);
    longint p, s, nacc;
    beat_t  b, cur;
    bit     have, emit;
    p = longint'($signed(a)) * longint'($signed(w));
    e_a = a; e_w = w; e_v = v; e_f = f; e_l = l;
    for (int i = 0; i < NI; i++) begin
      b.v = v; b.f = f; b.l = l; b.p = p;
      pq[i].push_back(b);
      have = 0;
      cur  = b;
      if (pq[i].size() > lat_of(i)) begin
        cur  = pq[i].pop_front();
        have = 1;
      end
      emit = !rv && m_hv[i];
      if (rv) begin
        m_res[i] = longint'(rin); m_rv[i] = 1;
      end else if (m_hv[i]) begin
        m_res[i] = m_hold[i]; m_rv[i] = 1;
      end else begin
        m_rv[i] = 0;
      end
      if (emit) m_hv[i] = 0;
      if (clr) begin m_sat[i] = 0; m_ovf[i] = 0; end
      if (have && cur.v) begin
        if (cur.f) begin
          nacc = cur.p;
        end else begin
          s = m_acc[i] + cur.p;
          if (sat_of(i)) begin
            if (s > ACC_MAX) begin s = ACC_MAX; m_sat[i] = 1; end
            else if (s < ACC_MIN) begin s = ACC_MIN; m_sat[i] = 1; end
          end else begin
            s = s & MASK;
            if (s > ACC_MAX) s = s - WRAP;
          end
          nacc = s;
        end
        m_acc[i] = nacc;
        if (cur.l) begin
          if (m_hv[i]) m_ovf[i] = 1;
          else begin m_hold[i] = nacc; m_hv[i] = 1; end
        end
      end
    end
  endtask

  // Per-cycle compare of every instance against the model
  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else model_step(a_in, w_in, valid_in, first_in, last_in, res_valid_in, res_in, clr_flags);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("a_out",     i, longint'(a_out_w[i]),       longint'(e_a));
      chk("w_out",     i, longint'(w_out_w[i]),       longint'(e_w));
      chk("valid_out", i, longint'(valid_out_w[i]),   longint'(e_v));
      chk("first_out", i, longint'(first_out_w[i]),   longint'(e_f));
      chk("last_out",  i, longint'(last_out_w[i]),    longint'(e_l));
      chk("res_valid", i, longint'(res_valid_out_w[i]), longint'(m_rv[i]));
      chk("res_out",   i, longint'(res_out_w[i]),     m_res[i] & MASK);
      chk("sat_flag",  i, longint'(sat_flag_w[i]),    longint'(m_sat[i]));
      chk("ovf_err",   i, longint'(ovf_err_w[i]),     longint'(m_ovf[i]));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic drive(input logic [7:0] a, input logic [7:0] w,
                       input logic v, input logic f, input logic l,
                       input logic rv, input logic [23:0] rin, input logic clr);
    @(negedge clk);
    a_in = a; w_in = w; valid_in = v; first_in = f; last_in = l;
    res_valid_in = rv; res_in = rin; clr_flags = clr;
  endtask

  task automatic idle();
    drive(8'h00, 8'h00, 0, 0, 0, 0, 24'h0, 0);
  endtask

  task automatic chk_res(input string name, input int i, input logic v, input longint r);
    chk({name, "_valid"}, i, longint'(res_valid_out_w[i]), longint'(v));
    if (v) chk({name, "_data"}, i, longint'(res_out_w[i]), r);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout @%0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n = 1'b1;
    a_in = '0; w_in = '0; valid_in = 0; first_in = 0; last_in = 0;
    res_in = '0; res_valid_in = 0; clr_flags = 0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("rst_res_valid", i, longint'(res_valid_out_w[i]), 0);
      chk("rst_res_out",   i, longint'(res_out_w[i]), 0);
      chk("rst_a_out",     i, longint'(a_out_w[i]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Forwarding, then an invalid beat carrying last that must be ignored
    drive(8'h05, 8'hFD, 1, 1, 0, 0, 24'h0, 0);
    drive(8'h11, 8'h22, 0, 0, 1, 0, 24'h0, 0);
    chk("fwd_a",     0, longint'(a_out_w[0]), 64'h05);
    chk("fwd_w",     0, longint'(w_out_w[0]), 64'hFD);
    chk("fwd_valid", 0, longint'(valid_out_w[0]), 1);
    chk("fwd_first", 0, longint'(first_out_w[0]), 1);
    idle();
    chk("fwd_a2",     0, longint'(a_out_w[0]), 64'h11);
    chk("fwd_valid2", 0, longint'(valid_out_w[0]), 0);
    chk("fwd_last2",  0, longint'(last_out_w[0]), 1);
    repeat (3) idle();

    // Signed dot product: 12 - 10 - 7 + 64 = 59
    drive(8'd3,  8'd4,  1, 1, 0, 0, 24'h0, 0);
    drive(8'hFE, 8'd5,  1, 0, 0, 0, 24'h0, 0);
    drive(8'd7,  8'hFF, 1, 0, 0, 0, 24'h0, 0);
    drive(8'hF8, 8'hF8, 1, 0, 1, 0, 24'h0, 0);
    idle();
    @(posedge clk); #2;
    chk_res("dot_e2", 1, 1, 59);
    chk_res("dot_e2", 0, 0, 0);
    @(posedge clk); #2;
    chk_res("dot_e3", 0, 1, 59);
    chk_res("dot_e3", 2, 1, 59);
    chk_res("dot_e3", 1, 0, 0);
    repeat (3) idle();

    // Saturation: 513 x 16384 overflows the 24-bit signed range
    for (int k = 0; k < 513; k++)
      drive(8'h80, 8'h80, 1, (k == 0), (k == 512), 0, 24'h0, 0);
    idle();
    @(posedge clk); #2;
    chk_res("sat_e2", 1, 1, 64'h7FFFFF);
    @(posedge clk); #2;
    chk_res("sat_e3", 0, 1, 64'h7FFFFF);
    chk("sat_flag",   0, longint'(sat_flag_w[0]), 1);
    chk_res("wrap_e3", 2, 1, 64'h804000);
    chk("wrap_sat_flag", 2, longint'(sat_flag_w[2]), 0);
    drive(8'h00, 8'h00, 0, 0, 0, 0, 24'h0, 1);
    idle();
    chk("sat_clr", 0, longint'(sat_flag_w[0]), 0);
    repeat (2) idle();

    // Back-to-back single-beat frames: emit and capture in the same cycle
    drive(8'd1, 8'd2, 1, 1, 1, 0, 24'h0, 0);
    drive(8'd2, 8'd2, 1, 1, 1, 0, 24'h0, 0);
    repeat (5) idle();
    chk("b2b_no_ovf", 0, longint'(ovf_err_w[0]), 0);
    chk("b2b_no_ovf", 1, longint'(ovf_err_w[1]), 0);

    // Drain priority: upstream beats first, local 42 after the chain frees
    drive(8'd6, 8'd7, 1, 1, 1, 0, 24'd0,   0);
    drive(8'd0, 8'd0, 0, 0, 0, 1, 24'd100, 0);
    drive(8'd0, 8'd0, 0, 0, 0, 1, 24'd101, 0);
    drive(8'd0, 8'd0, 0, 0, 0, 1, 24'd102, 0);
    idle();
    chk_res("drain_up", 0, 1, 102);
    @(posedge clk); #2;
    for (int i = 0; i < NI; i++) begin
      chk_res("drain_local", i, 1, 42);
      chk("drain_no_ovf", i, longint'(ovf_err_w[i]), 0);
    end
    repeat (3) idle();

    // Hold overflow: 6 kept and emitted later, 9 dropped
    drive(8'd2, 8'd3, 1, 1, 1, 1, 24'd200, 0);
    drive(8'd3, 8'd3, 1, 1, 1, 1, 24'd201, 0);
    drive(8'd0, 8'd0, 0, 0, 0, 1, 24'd202, 0);
    drive(8'd0, 8'd0, 0, 0, 0, 1, 24'd203, 0);
    idle();
    @(posedge clk); #2;
    for (int i = 0; i < NI; i++) begin
      chk_res("ovf_emit6", i, 1, 6);
      chk("ovf_err", i, longint'(ovf_err_w[i]), 1);
    end
    @(posedge clk); #2;
    chk_res("ovf_no9", 0, 0, 0);
    repeat (3) idle();
    drive(8'h00, 8'h00, 0, 0, 0, 0, 24'h0, 1);
    idle();
    chk("ovf_clr", 0, longint'(ovf_err_w[0]), 0);

    // Asynchronous reset mid-frame, between clock edges
    drive(8'd2, 8'd5, 1, 1, 0, 0, 24'h0, 0);
    drive(8'd3, 8'd3, 1, 0, 0, 0, 24'h0, 0);
    #2;
    rst_n = 1'b0;
    a_in = '0; w_in = '0; valid_in = 0; first_in = 0; last_in = 0;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("arst_a_out",     i, longint'(a_out_w[i]), 0);
      chk("arst_w_out",     i, longint'(w_out_w[i]), 0);
      chk("arst_valid_out", i, longint'(valid_out_w[i]), 0);
      chk("arst_first_out", i, longint'(first_out_w[i]), 0);
      chk("arst_res_out",   i, longint'(res_out_w[i]), 0);
      chk("arst_res_valid", i, longint'(res_valid_out_w[i]), 0);
      chk("arst_flags",     i, longint'({sat_flag_w[i], ovf_err_w[i]}), 0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(8'd2, 8'd3, 1, 1, 1, 0, 24'h0, 0);
    idle();
    @(posedge clk); #2;
    chk_res("post_rst_e2", 1, 1, 6);
    @(posedge clk); #2;
    chk_res("post_rst_e3", 0, 1, 6);
    repeat (6) idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
